// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer for the 8x16 systolic tensor core: walks (A,B) tile pairs, issues C/A/B/D AXI
// requests and steps SYSTOLIC/ACCUMULATE/WRITE_BACK. Define SYSSEQ_BPREFETCH_EN for B prefetch.
module systolic_seq_ctrl #(
   parameter int SYS_CYCLES = 38,
   parameter int ACC_CYCLES = 8,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       full_type,
   input  logic             axi_finish,
   output logic             req_valid,
   output logic [2:0]       req_sel,
   output logic [1:0]       req_a_idx,
   output logic [1:0]       req_b_idx,
   output logic [3:0]       state,
   output logic [2:0]       pattern,
   output logic             sys_en,
   output logic [CNT_W-1:0] sys_cycle,
   output logic             acc_en,
   output logic             wb_en,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);
   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      READ_C     = 4'd1,
      WAIT_A     = 4'd2,
      WAIT_B     = 4'd3,
      SYSTOLIC   = 4'd4,
      ACCUMULATE = 4'd5,
      WRITE_BACK = 4'd6,
      FINISH     = 4'd7
   } state_t;

   typedef enum logic [2:0] {
      NOMAL     = 3'd0,
      BROADCAST = 3'd1
   } pattern_t;

   localparam logic [2:0]       SEL_A    = 3'b100;
   localparam logic [2:0]       SEL_B    = 3'b010;
   localparam logic [2:0]       SEL_C    = 3'b001;
   localparam logic [2:0]       SEL_D    = 3'b000;
   localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYCLES - 1);

   state_t           state_q, state_d;
   pattern_t         pattern_q, pattern_d;
   logic [1:0]       a_q, a_d, b_q, b_d;
   logic [1:0]       na_last_q, na_last_d, nb_last_q, nb_last_d;
   logic             is_int_q, is_int_d;
   logic             req_valid_q, req_valid_d;
   logic [2:0]       req_sel_q, req_sel_d;
   logic [1:0]       req_a_q, req_a_d, req_b_q, req_b_d;
   logic             sys_en_q, sys_en_d;
   logic [CNT_W-1:0] sys_cycle_q, sys_cycle_d;
   logic             acc_en_q, acc_en_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic             wb_en_q, wb_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cfg_err_q, cfg_err_d;

   logic             fin, iss, go_sys, go_wb, load_b;
   logic [2:0]       iss_sel;
   logic [1:0]       iss_a, iss_b;
   logic             pf_hit;

`ifdef SYSSEQ_BPREFETCH_EN
   logic             pf_vld_q, pf_vld_d;
   logic [1:0]       pf_idx_q, pf_idx_d;
   // A completed prefetch of this tile's B makes WAIT_B unnecessary.
   assign pf_hit = pf_vld_q && (pf_idx_q == b_q);
`else
   assign pf_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      a_d         = a_q;
      b_d         = b_q;
      na_last_d   = na_last_q;
      nb_last_d   = nb_last_q;
      is_int_d    = is_int_q;
      fin         = req_valid_q && axi_finish;
      req_valid_d = req_valid_q && !axi_finish;
      req_sel_d   = req_sel_q;
      req_a_d     = req_a_q;
      req_b_d     = req_b_q;
      sys_en_d    = 1'b0;
      sys_cycle_d = '0;
      acc_en_d    = 1'b0;
      acc_cnt_d   = '0;
      wb_en_d     = 1'b0;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
      iss         = 1'b0;
      iss_sel     = SEL_D;
      iss_a       = a_q;
      iss_b       = b_q;
      go_sys      = 1'b0;
      go_wb       = 1'b0;
      load_b      = 1'b0;
`ifdef SYSSEQ_BPREFETCH_EN
      pf_vld_d    = pf_vld_q;
      pf_idx_d    = pf_idx_q;
      if (fin && state_q == SYSTOLIC) pf_vld_d = 1'b1;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               if (full_type > 4'd11) begin
                  cfg_err_d = 1'b1;
               end else begin
                  // full_type = 3*datatype + shape; shape 0:m16n16, 1:m8n32, 2:m32n8
                  case (full_type)
                     4'd0, 4'd3, 4'd6, 4'd9:  begin na_last_d = 2'd1; nb_last_d = 2'd0; end
                     4'd1, 4'd4, 4'd7, 4'd10: begin na_last_d = 2'd0; nb_last_d = 2'd1; end
                     default:                 begin na_last_d = 2'd3; nb_last_d = 2'd0; end
                  endcase
                  is_int_d  = (full_type >= 4'd6);
                  pattern_d = (full_type >= 4'd6) ? BROADCAST : NOMAL;
                  a_d       = 2'd0;
                  b_d       = 2'd0;
                  state_d   = READ_C;
                  iss       = 1'b1;
                  iss_sel   = SEL_C;
                  iss_a     = 2'd0;
                  iss_b     = 2'd0;
`ifdef SYSSEQ_BPREFETCH_EN
                  pf_vld_d  = 1'b0;
`endif
               end
            end
         end
         READ_C: begin
            if (fin) begin
               if (b_q == 2'd0) begin
                  state_d = WAIT_A;
                  iss     = 1'b1;
                  iss_sel = SEL_A;
               end else begin
                  load_b = 1'b1;
               end
            end
         end
         WAIT_A: if (fin) load_b = 1'b1;
         WAIT_B: if (fin) go_sys = 1'b1;
         SYSTOLIC: begin
            if (sys_cycle_q != SYS_LAST) begin
               sys_en_d    = 1'b1;
               sys_cycle_d = sys_cycle_q + CNT_W'(1);
            end else if (!req_valid_q || axi_finish) begin
               if (is_int_q) acc_en_d = 1'b1;
               else          go_wb    = 1'b1;
               if (is_int_q) state_d  = ACCUMULATE;
            end else begin
               // Count done but prefetch still in flight: hold the last index with the array idle.
               sys_cycle_d = SYS_LAST;
            end
         end
         ACCUMULATE: begin
            if (acc_cnt_q == ACC_LAST) begin
               go_wb = 1'b1;
            end else begin
               acc_en_d  = 1'b1;
               acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
         end
         WRITE_BACK: begin
            if (fin) begin
               if (b_q < nb_last_q) begin
                  b_d     = b_q + 2'd1;
                  state_d = READ_C;
                  iss     = 1'b1;
                  iss_sel = SEL_C;
                  iss_b   = b_q + 2'd1;
               end else if (a_q < na_last_q) begin
                  a_d     = a_q + 2'd1;
                  b_d     = 2'd0;
                  state_d = READ_C;
                  iss     = 1'b1;
                  iss_sel = SEL_C;
                  iss_a   = a_q + 2'd1;
                  iss_b   = 2'd0;
               end else begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end
            end else begin
               wb_en_d = 1'b1;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (load_b) begin
         if (pf_hit) begin
            go_sys = 1'b1;
         end else begin
            state_d = WAIT_B;
            iss     = 1'b1;
            iss_sel = SEL_B;
         end
      end
      if (go_sys) begin
         state_d     = SYSTOLIC;
         sys_en_d    = 1'b1;
         sys_cycle_d = '0;
`ifdef SYSSEQ_BPREFETCH_EN
         pf_vld_d    = 1'b0;
         if (b_q < nb_last_q) begin
            iss      = 1'b1;
            iss_sel  = SEL_B;
            iss_b    = b_q + 2'd1;
            pf_idx_d = b_q + 2'd1;
         end
`endif
      end
      if (go_wb) begin
         state_d = WRITE_BACK;
         wb_en_d = 1'b1;
         iss     = 1'b1;
         iss_sel = SEL_D;
      end
      if (iss) begin
         req_valid_d = 1'b1;
         req_sel_d   = iss_sel;
         req_a_d     = iss_a;
         req_b_d     = iss_b;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pattern_q   <= NOMAL;
         a_q         <= 2'd0;
         b_q         <= 2'd0;
         na_last_q   <= 2'd0;
         nb_last_q   <= 2'd0;
         is_int_q    <= 1'b0;
         req_valid_q <= 1'b0;
         req_sel_q   <= 3'd0;
         req_a_q     <= 2'd0;
         req_b_q     <= 2'd0;
         sys_en_q    <= 1'b0;
         sys_cycle_q <= '0;
         acc_en_q    <= 1'b0;
         acc_cnt_q   <= '0;
         wb_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
`ifdef SYSSEQ_BPREFETCH_EN
         pf_vld_q    <= 1'b0;
         pf_idx_q    <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         a_q         <= a_d;
         b_q         <= b_d;
         na_last_q   <= na_last_d;
         nb_last_q   <= nb_last_d;
         is_int_q    <= is_int_d;
         req_valid_q <= req_valid_d;
         req_sel_q   <= req_sel_d;
         req_a_q     <= req_a_d;
         req_b_q     <= req_b_d;
         sys_en_q    <= sys_en_d;
         sys_cycle_q <= sys_cycle_d;
         acc_en_q    <= acc_en_d;
         acc_cnt_q   <= acc_cnt_d;
         wb_en_q     <= wb_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
`ifdef SYSSEQ_BPREFETCH_EN
         pf_vld_q    <= pf_vld_d;
         pf_idx_q    <= pf_idx_d;
`endif
      end
   end

   assign state     = state_q;
   assign pattern   = pattern_q;
   assign req_valid = req_valid_q;
   assign req_sel   = req_sel_q;
   assign req_a_idx = req_a_q;
   assign req_b_idx = req_b_q;
   assign sys_en    = sys_en_q;
   assign sys_cycle = sys_cycle_q;
   assign acc_en    = acc_en_q;
   assign wb_en     = wb_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl: a loop-structured walk of the tile schedule predicts
// every output each cycle and also drives the AXI completion pulses.
`timescale 1ns/1ps
module tb_systolic_seq_ctrl;
   localparam int SYS = 38;
   localparam int ACC = 8;
   localparam logic [3:0] S_IDLE = 4'd0, S_RC = 4'd1, S_WA = 4'd2, S_WB = 4'd3,
                          S_SYS = 4'd4, S_ACC = 4'd5, S_WBK = 4'd6, S_FIN = 4'd7;
`ifdef SYSSEQ_BPREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, axi_finish;
   logic [3:0] full_type;
   logic       req_valid, sys_en, acc_en, wb_en, busy, done, cfg_err;
   logic [2:0] req_sel, pattern;
   logic [1:0] req_a_idx, req_b_idx;
   logic [3:0] state;
   logic [5:0] sys_cycle;

   systolic_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .full_type(full_type), .axi_finish(axi_finish),
      .req_valid(req_valid), .req_sel(req_sel), .req_a_idx(req_a_idx), .req_b_idx(req_b_idx),
      .state(state), .pattern(pattern), .sys_en(sys_en), .sys_cycle(sys_cycle),
      .acc_en(acc_en), .wb_en(wb_en), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   logic [3:0] e_state;
   logic       e_valid, e_sys, e_acc, e_wb, e_busy, e_done, e_err;
   logic [2:0] e_sel, e_pat, pat_next;
   logic [1:0] e_a, e_b;
   logic [5:0] e_cyc;
   bit         chk_en = 1'b0;
   int         n_tests = 0, n_fail = 0;
   int         fixed_dly = -1;

   int         sys_cnt = 0, acc_cnt = 0, done_cnt = 0, wait_cnt = 0;
   int         reqs[$];
   logic       prev_v = 1'b0;
   logic [6:0] prev_req = 7'd0;
   int         b_sys, b_acc, b_done, b_wait, b_req;
   int         ex[$];

   task automatic check(input string nm, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("state", state, e_state);
         check("req_valid", req_valid, e_valid);
         if (e_valid) begin
            check("req_sel", req_sel, e_sel);
            check("req_a_idx", req_a_idx, e_a);
            check("req_b_idx", req_b_idx, e_b);
         end
         check("pattern", pattern, e_pat);
         check("sys_en", sys_en, e_sys);
         check("sys_cycle", sys_cycle, e_cyc);
         check("acc_en", acc_en, e_acc);
         check("wb_en", wb_en, e_wb);
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("cfg_err", cfg_err, e_err);
      end
      if (sys_en) sys_cnt++;
      if (acc_en) acc_cnt++;
      if (done) done_cnt++;
      if (state == S_SYS && !sys_en) wait_cnt++;
      if (req_valid && (!prev_v || {req_sel, req_a_idx, req_b_idx} != prev_req))
         reqs.push_back(int'({req_sel, req_a_idx, req_b_idx}));
      prev_v   = req_valid;
      prev_req = {req_sel, req_a_idx, req_b_idx};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_exp();
      e_state = S_IDLE; e_valid = 1'b0; e_sys = 1'b0; e_cyc = 6'd0; e_acc = 1'b0;
      e_wb = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      start = 1'b0;
      axi_finish = 1'($urandom % 2);
   endtask

   // Busy cycles also carry stray start pulses and stray completions, all of which must be ignored.
   task automatic busy_exp(input logic [3:0] st);
      e_state = st; e_valid = 1'b0; e_sys = 1'b0; e_cyc = 6'd0; e_acc = 1'b0;
      e_wb = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_pat = pat_next;
      start = 1'($urandom % 4 == 0);
      full_type = 4'($urandom);
      axi_finish = 1'($urandom % 2);
   endtask

   task automatic req(input logic [3:0] st, input logic [2:0] sel, input int a, input int b);
      int d;
      d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
      for (int k = 0; k <= d; k++) begin
         tick();
         busy_exp(st);
         e_valid = 1'b1; e_sel = sel; e_a = 2'(a); e_b = 2'(b);
         e_wb = (st == S_WBK);
         axi_finish = (k == d);
      end
   endtask

   task automatic run_op(input int t, input int pf_dly);
      int na, nb, tot;
      bit is_int, pfreq;
      na = (t % 3 == 0) ? 2 : (t % 3 == 1) ? 1 : 4;
      nb = (t % 3 == 1) ? 2 : 1;
      is_int = (t / 3) >= 2;
      tick();
      idle_exp();
      start = 1'b1;
      full_type = 4'(t);
      pat_next = is_int ? 3'd1 : 3'd0;
      for (int a = 0; a < na; a++) begin
         for (int b = 0; b < nb; b++) begin
            req(S_RC, 3'b001, a, b);
            if (b == 0) req(S_WA, 3'b100, a, b);
            if (!(PF && b > 0)) req(S_WB, 3'b010, a, b);
            pfreq = PF && (b < nb - 1);
            tot = (pfreq && pf_dly + 1 > SYS) ? pf_dly + 1 : SYS;
            for (int c = 0; c < tot; c++) begin
               tick();
               busy_exp(S_SYS);
               e_sys = (c < SYS);
               e_cyc = 6'((c < SYS) ? c : SYS - 1);
               if (pfreq && c <= pf_dly) begin
                  e_valid = 1'b1; e_sel = 3'b010; e_a = 2'(a); e_b = 2'(b + 1);
                  axi_finish = (c == pf_dly);
               end
            end
            if (is_int) begin
               for (int c = 0; c < ACC; c++) begin
                  tick();
                  busy_exp(S_ACC);
                  e_acc = 1'b1;
               end
            end
            req(S_WBK, 3'b000, a, b);
         end
      end
      tick();
      busy_exp(S_FIN);
      e_done = 1'b1;
   endtask

   task automatic bad_start(input int t);
      tick();
      idle_exp();
      start = 1'b1;
      full_type = 4'(t);
      tick();
      idle_exp();
      e_err = 1'b1;
   endtask

   task automatic mark();
      b_sys = sys_cnt; b_acc = acc_cnt; b_done = done_cnt; b_wait = wait_cnt; b_req = reqs.size();
   endtask

   task automatic pin(input string nm, input int sys_e, input int acc_e, input int wait_e);
      int n;
      tick(); idle_exp();
      tick(); idle_exp();
      check({nm, "_sys_cycles"}, sys_cnt - b_sys, sys_e);
      check({nm, "_acc_cycles"}, acc_cnt - b_acc, acc_e);
      check({nm, "_done_pulses"}, done_cnt - b_done, 1);
      check({nm, "_sys_wait"}, wait_cnt - b_wait, wait_e);
      n = reqs.size() - b_req;
      check({nm, "_req_count"}, n, ex.size());
      for (int i = 0; i < n && i < ex.size(); i++)
         check({nm, "_req_code"}, reqs[b_req + i], ex[i]);
   endtask

   initial begin
      bit found;
      rst = 1'b1; full_type = 4'd0; e_pat = 3'd0; pat_next = 3'd0;
      e_sel = 3'd0; e_a = 2'd0; e_b = 2'd0;
      idle_exp();
      chk_en = 1'b1;
      #2;
      check("rst_state", state, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pattern", pattern, 0);
      repeat (3) begin tick(); idle_exp(); end
      rst = 1'b0;
      tick(); idle_exp();

      // FP32 m16n16: two A tiles, one B tile, fixed 2-cycle completions.
      fixed_dly = 2;
      mark();
      run_op(0, 0);
      ex = {16, 64, 32, 0, 20, 68, 36, 4};
      pin("fp32_m16n16", 76, 0, 0);
      fixed_dly = -1;

      // INT8 m8n32: one A tile, two B tiles.
      mark();
      run_op(7, 10);
      if (PF) ex = {16, 64, 32, 33, 0, 17, 1};
      else    ex = {16, 64, 32, 0, 17, 33, 1};
      pin("int8_m8n32", 76, 16, 0);
      check("int8_pattern", pattern, 1);

      // FP16 m32n8: four A tiles.
      mark();
      run_op(5, 0);
      ex = {16, 64, 32, 0, 20, 68, 36, 4, 24, 72, 40, 8, 28, 76, 44, 12};
      pin("fp16_m32n8", 152, 0, 0);

      bad_start(13);
      bad_start(15);
      tick(); idle_exp();
      check("bad_start_pattern", pattern, 0);

      // Reset while a B request is outstanding.
      chk_en = 1'b0;
      tick(); start = 1'b1; full_type = 4'd0; axi_finish = 1'b1;
      tick(); start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (state == S_WB) found = 1'b1;
      end
      check("reach_wait_b", found, 1);
      check("wait_b_req_valid", req_valid, 1);
      axi_finish = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_rst_req_valid", req_valid, 0);
      check("async_rst_state", state, 0);
      check("async_rst_busy", busy, 0);
      tick(); tick();
      rst = 1'b0;
      tick(); idle_exp(); e_pat = 3'd0; pat_next = 3'd0;
      chk_en = 1'b1;
      mark();
      run_op(0, 0);
      ex = {16, 64, 32, 0, 20, 68, 36, 4};
      pin("after_rst", 76, 0, 0);

      // INT4 m8n32 with a slow prefetch completion.
      mark();
      run_op(10, 50);
      if (PF) ex = {16, 64, 32, 33, 0, 17, 1};
      else    ex = {16, 64, 32, 0, 17, 33, 1};
      pin("int4_slow_pf", 76, 16, PF ? 13 : 0);

      for (int r = 0; r < 16; r++) begin
         if ($urandom % 4 == 0) bad_start(int'($urandom_range(12, 15)));
         run_op(int'($urandom_range(0, 11)), int'($urandom_range(0, 60)));
         repeat ($urandom_range(0, 3)) begin tick(); idle_exp(); end
      end
      tick(); idle_exp();
      tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
